// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the execute-stage control and the RV32M
// multiply/divide unit.
interface rv32m_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      MDOp;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Res;

    modport master (
        output start, A, B, MDOp,
        input  busy, done, Res
    );

    modport slave (
        input  start, A, B, MDOp,
        output busy, done, Res
    );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes. Define MULDIV_EARLY_OUT_EN to resolve trivial operands in one cycle.
module rv32m_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input logic                clk,
    input logic                rst,
    rv32m_muldiv_unit_if.slave mdu
);
    localparam int                CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Results for operands that need no iteration: divide by zero, signed overflow, zero A.
    function automatic logic [XLEN-1:0] early_res(input logic [2:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        if (op[2]) begin
            if (b == '0)
                return op[1] ? a : '1;
            if (!op[0] && a == INT_MIN && b == '1)
                return op[1] ? '0 : INT_MIN;
        end
        return '0;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                div0_q, div0_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                in_div, a_sgn, b_sgn, neg_a, neg_b, accept;
    logic [XLEN-1:0]     a_mag, b_mag;

    assign in_div = mdu.MDOp[2];
    assign a_sgn  = in_div ? ~mdu.MDOp[0] : (mdu.MDOp[1:0] != 2'b11);
    assign b_sgn  = in_div ? ~mdu.MDOp[0] : ~mdu.MDOp[1];
    assign neg_a  = a_sgn & mdu.A[XLEN-1];
    assign neg_b  = b_sgn & mdu.B[XLEN-1];
    assign a_mag  = neg_if(mdu.A, neg_a);
    assign b_mag  = neg_if(mdu.B, neg_b);

    // Multiply: acc = {partial high, multiplier shifting out of the low half}.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    // Divide: acc = {partial remainder, dividend shifting into quotient bits}.
    logic [XLEN:0]       div_sh;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_rem  = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
        div_next = {div_rem, acc_q[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     fix_res;

    always_comb begin
        prod = neg_wide_if(acc_q, neg_q);
        if (!op_q[2])
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (!op_q[1])
            fix_res = div0_q ? '1 : neg_if(acc_q[XLEN-1:0], neg_q);
        else
            fix_res = neg_if(acc_q[2*XLEN-1:XLEN], neg_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        div0_d  = div0_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: accept = mdu.start;
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                res_d   = fix_res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                accept  = mdu.start;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d    = mdu.MDOp;
            opnd_d  = in_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
            // REM takes the dividend's sign; DIV and multiplies take the XOR.
            neg_d   = (in_div && mdu.MDOp[1]) ? neg_a : (neg_a ^ neg_b);
            div0_d  = (mdu.B == '0);
            cnt_d   = '0;
            state_d = S_CALC;
            busy_d  = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (mdu.B == '0 || mdu.A == '0 ||
                (in_div && !mdu.MDOp[0] && mdu.A == INT_MIN && mdu.B == '1)) begin
                res_d   = early_res(mdu.MDOp, mdu.A, mdu.B);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.done = done_q;
    assign mdu.Res  = res_q;
endmodule
